// File: rtl/pc_sequencer.sv
// Multi-cycle instruction sequencer: steps IF/ID/EXE/MEM/WB, strobes PCWre once per
// retired instruction and forms the next-PC value for the PC register.
//   state | meaning
//   IF    | fetch, instruction register loads
//   ID    | decode; jumps retire here
//   EXE   | execute; branches retire here
//   MEM   | data memory access, waits on mem_ready; stores retire here
//   WB    | register writeback; R-type and loads retire here
//   HALT  | parked until reset
module pc_sequencer #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_BNE   = 6'b000101,
    parameter logic [5:0] OP_J     = 6'b000010,
    parameter logic [5:0] OP_HALT  = 6'b111111
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic        zero,
    input  logic [31:0] pc_cur,
    input  logic [31:0] imm_ext,
    input  logic [25:0] jtarget,
    input  logic        mem_ready,
    output logic        PCWre,
    output logic        ir_we,
    output logic        mem_en,
    output logic [31:0] next_pc,
    output logic [2:0]  state,
    output logic        halted,
    output logic [31:0] instr_count
);

    typedef enum logic [2:0] {
        S_IF   = 3'b000,
        S_ID   = 3'b001,
        S_EXE  = 3'b010,
        S_MEM  = 3'b011,
        S_WB   = 3'b100,
        S_HALT = 3'b111
    } state_t;

    state_t      st;
    logic        is_branch;
    logic        taken;
    logic [31:0] pc4;

    assign is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE);
    assign taken     = ((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero);
    assign pc4       = pc_cur + 32'd4;

    always_comb begin
        next_pc = pc4;
        if (opcode == OP_J)
            next_pc = {pc4[31:28], jtarget, 2'b00};
        else if (taken)
            next_pc = pc4 + (imm_ext << 2);
    end

    assign state  = st;
    assign ir_we  = (st == S_IF);
    // Strobe-type outputs are masked while reset is held so an aborted instruction never retires.
    assign mem_en = reset && (st == S_MEM);
    assign halted = reset && (st == S_HALT);

    always_comb begin
        PCWre = 1'b0;
        case (st)
            S_ID:  PCWre = (opcode == OP_J);
            S_EXE: PCWre = is_branch;
            S_MEM: PCWre = (opcode == OP_SW) && mem_ready;
            S_WB:  PCWre = 1'b1;
            default: PCWre = 1'b0;
        endcase
        if (!reset)
            PCWre = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            st          <= S_IF;
            instr_count <= '0;
        end else begin
            if (PCWre)
                instr_count <= instr_count + 32'd1;
            case (st)
                S_IF:  st <= S_ID;
                S_ID: begin
                    if (opcode == OP_J)
                        st <= S_IF;
                    else if (opcode == OP_HALT)
                        st <= S_HALT;
                    else
                        st <= S_EXE;
                end
                S_EXE: begin
                    if (is_branch)
                        st <= S_IF;
                    else if ((opcode == OP_LW) || (opcode == OP_SW))
                        st <= S_MEM;
                    else
                        st <= S_WB;
                end
                S_MEM: begin
                    if (mem_ready)
                        st <= (opcode == OP_LW) ? S_WB : S_IF;
                end
                S_WB:   st <= S_IF;
                S_HALT: st <= S_HALT;
                default: st <= S_IF;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a vector table of single instructions plus
// hand sequences for reset, memory stalls, halt and mid-instruction reset.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic        zero;
    logic [31:0] pc_cur;
    logic [31:0] imm_ext;
    logic [25:0] jtarget;
    logic        mem_ready;
    logic        PCWre;
    logic        ir_we;
    logic        mem_en;
    logic [31:0] next_pc;
    logic [2:0]  state;
    logic        halted;
    logic [31:0] instr_count;

    int tests = 0;
    int fails = 0;

    pc_sequencer dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .pc_cur(pc_cur),
        .imm_ext(imm_ext), .jtarget(jtarget), .mem_ready(mem_ready), .PCWre(PCWre),
        .ir_we(ir_we), .mem_en(mem_en), .next_pc(next_pc), .state(state),
        .halted(halted), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic        z;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [25:0] jt;
        int          waits;
        int          lat;
        logic [31:0] npc;
        logic [2:0]  fin;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Runs one instruction starting just after a falling edge with the FSM in IF.
    task automatic run_vec(input int idx, input vec_t v);
        int cyc = 0;
        int waited = 0;
        bit seen = 0;
        logic [31:0] cnt0;
        opcode = v.op; zero = v.z; pc_cur = v.pc; imm_ext = v.imm; jtarget = v.jt;
        mem_ready = 1'b0;
        cnt0 = instr_count;
        #1;
        check($sformatf("v%0d start_state", idx), {29'd0, state}, 32'd0);
        check($sformatf("v%0d ir_we_in_if", idx), {31'd0, ir_we}, 32'd1);
        while (!seen && cyc < 40) begin
            mem_ready = (state == 3'b011) && (waited >= v.waits);
            if (state == 3'b011 && !mem_ready) waited++;
            #1;
            cyc++;
            if (PCWre) begin
                seen = 1;
                check($sformatf("v%0d latency", idx), cyc, v.lat);
                check($sformatf("v%0d next_pc", idx), next_pc, v.npc);
                check($sformatf("v%0d retire_state", idx), {29'd0, state}, {29'd0, v.fin});
            end
            @(negedge clk);
        end
        check($sformatf("v%0d pcwre_seen", idx), {31'd0, seen}, 32'd1);
        mem_ready = 1'b0;
        #1;
        check($sformatf("v%0d back_to_if", idx), {29'd0, state}, 32'd0);
        check($sformatf("v%0d count", idx), instr_count, cnt0 + 32'd1);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        reset = 1'b0;
        repeat (cycles) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic [2:0] exp_states[8];
        int pc_hits;

        vecs[0]  = '{6'b000000, 1'b0, 32'h10,       32'h0,        26'h0,  0, 4, 32'h14,       3'b100};
        vecs[1]  = '{6'b000100, 1'b1, 32'h10,       32'hFFFFFFFE, 26'h0,  0, 3, 32'h0C,       3'b010};
        vecs[2]  = '{6'b000100, 1'b0, 32'h10,       32'hFFFFFFFE, 26'h0,  0, 3, 32'h14,       3'b010};
        vecs[3]  = '{6'b000101, 1'b0, 32'h10,       32'hFFFFFFFE, 26'h0,  0, 3, 32'h0C,       3'b010};
        vecs[4]  = '{6'b000101, 1'b1, 32'h10,       32'hFFFFFFFE, 26'h0,  0, 3, 32'h14,       3'b010};
        vecs[5]  = '{6'b000010, 1'b0, 32'hF0000000, 32'h0,        26'h40, 0, 2, 32'hF0000100, 3'b001};
        vecs[6]  = '{6'b101011, 1'b0, 32'h100,      32'h0,        26'h0,  0, 4, 32'h104,      3'b011};
        vecs[7]  = '{6'b101011, 1'b0, 32'h200,      32'h0,        26'h0,  2, 6, 32'h204,      3'b011};
        vecs[8]  = '{6'b100011, 1'b0, 32'h300,      32'h0,        26'h0,  0, 5, 32'h304,      3'b100};
        vecs[9]  = '{6'b001000, 1'b1, 32'hFFFFFFFC, 32'h0,        26'h0,  0, 4, 32'h0,        3'b100};
        vecs[10] = '{6'b000100, 1'b1, 32'h20,       32'h4,        26'h0,  0, 3, 32'h34,       3'b010};

        reset = 1'b0; opcode = 6'b000010; zero = 1'b0; pc_cur = 32'h0;
        imm_ext = 32'h0; jtarget = 26'h0; mem_ready = 1'b0;

        // Reset held for two cycles
        repeat (2) begin
            @(negedge clk);
            #1;
            check("rst state", {29'd0, state}, 32'd0);
            check("rst count", instr_count, 32'd0);
            check("rst pcwre", {31'd0, PCWre}, 32'd0);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("post_rst ir_we", {31'd0, ir_we}, 32'd1);

        for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

        // LW with three not-ready MEM cycles: full state trace
        exp_states = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b011, 3'b011, 3'b011, 3'b100};
        opcode = 6'b100011; pc_cur = 32'h40; pc_hits = 0;
        for (int c = 0; c < 8; c++) begin
            mem_ready = (c == 6);
            #1;
            check($sformatf("lw state c%0d", c), {29'd0, state}, {29'd0, exp_states[c]});
            if (state == 3'b011)
                check($sformatf("lw mem_en c%0d", c), {31'd0, mem_en}, 32'd1);
            if (PCWre) pc_hits++;
            @(negedge clk);
        end
        mem_ready = 1'b0;
        #1;
        check("lw pcwre_once", pc_hits, 1);
        check("lw back_to_if", {29'd0, state}, 32'd0);

        // mem_ready outside MEM must not disturb an R-type
        opcode = 6'b000000; mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rtype_ignores_ready", {29'd0, state}, 32'd4);
        @(negedge clk);
        mem_ready = 1'b0;

        // HALT parks the FSM
        opcode = 6'b111111;
        repeat (2) @(negedge clk);
        pc_hits = 0;
        for (int c = 0; c < 10; c++) begin
            mem_ready = c[0];
            #1;
            if (PCWre) pc_hits++;
            if (c == 9) begin
                check("halt state", {29'd0, state}, 32'd7);
                check("halt flag", {31'd0, halted}, 32'd1);
            end
            @(negedge clk);
        end
        check("halt no_pcwre", pc_hits, 0);
        mem_ready = 1'b0;
        do_reset(1);
        #1;
        check("halt exit_by_reset", {29'd0, state}, 32'd0);

        // Retire one instruction so the counter is nonzero, then abort an R-type in EXE
        run_vec(11, vecs[0]);
        opcode = 6'b000000;
        repeat (2) @(negedge clk);
        #1;
        check("abort in_exe", {29'd0, state}, 32'd2);
        reset = 1'b0;
        #1;
        check("abort pcwre", {31'd0, PCWre}, 32'd0);
        @(negedge clk);
        #1;
        check("abort state", {29'd0, state}, 32'd0);
        check("abort count", instr_count, 32'd0);
        reset = 1'b1;

        // Reset during ID of a jump masks the would-be strobe
        opcode = 6'b000010;
        @(negedge clk);
        #1;
        check("jmask in_id", {29'd0, state}, 32'd1);
        reset = 1'b0;
        #1;
        check("jmask pcwre", {31'd0, PCWre}, 32'd0);
        @(negedge clk);
        #1;
        check("jmask count", instr_count, 32'd0);
        reset = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
